sobel_stream: RTL and testbench
===============================

SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 The module SHALL have parameter IMG_WIDTH, default 640, meaning the number of pixels per line (range 4..2048).
REQ-002 The module SHALL have parameter WORD_SIZE, default 16, meaning the RGB565 pixel width (R[15:11], G[10:5], B[4:0]).
REQ-003 The module SHALL have parameter THRESHOLD, default 0, meaning the gradient magnitude below which a channel is forced to 0.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: in_pixel is accepted this cycle.
REQ-007 Port in_sof, input, 1 bit: qualified by in_valid; marks the first pixel of a frame.
REQ-008 Port in_pixel, input, WORD_SIZE bits: raster-order input pixel.
REQ-009 Port out_valid, output, 1 bit: out_pixel is valid this cycle.
REQ-010 Port out_sof, output, 1 bit: marks the first output pixel of a frame.
REQ-011 Port out_pixel, output, WORD_SIZE bits: filtered RGB565 pixel.

Function
REQ-012 FSM states SHALL be IDLE, FILL, RUN; IDLE->FILL on in_valid&in_sof; FILL->RUN on the first accepted pixel of row 2; RUN->FILL on in_valid&in_sof.
REQ-013 In IDLE, pixels without in_sof SHALL be discarded and out_valid SHALL stay 0.
REQ-014 Column counter SHALL wrap IMG_WIDTH-1 -> 0 and increment the row counter; in_sof SHALL force col=0, row=0 regardless of current position.
REQ-015 Two line buffers of depth IMG_WIDTH SHALL hold rows r-1 and r-2; a 3x3 window register SHALL shift only on accepted pixels.
REQ-016 Each accepted pixel in FILL or RUN SHALL produce exactly one output pixel, out_valid asserting exactly 2 cycles after the accept; in_valid gaps SHALL propagate as out_valid gaps.
REQ-017 The output for input (r,c) SHALL be the Sobel result centred at (r-1,c-1); if r<2 or c<2 out_pixel SHALL be 0.
REQ-018 Per channel: gx = (p2-p0)+2(p5-p3)+(p8-p6), gy = (p0-p6)+2(p1-p7)+(p2-p8), p0..p8 row-major with p0 top-left; signed width = channel width+3.
REQ-019 Magnitude = |gx|+|gy| at channel width+4; if < THRESHOLD, channel SHALL be 0; if > channel max (31 or 63), channel SHALL saturate to max; otherwise the value itself.
REQ-020 Pipeline: stage 1 registers gx/gy, stage 2 registers magnitude/threshold/saturation to out_pixel.
REQ-021 out_sof SHALL assert with the output belonging to the in_sof pixel.

Reset
REQ-022 On rst: state=IDLE, counters=0, window registers=0, out_valid=0, out_sof=0, out_pixel=0; line buffer contents SHALL not be reset.
REQ-023 Reset mid-frame SHALL drop all in-flight pipeline data; no out_valid SHALL follow until a new in_sof.

Configuration
REQ-024 With SOBEL_RGB_EN defined, R and B channels SHALL be filtered per REQ-018..019 in parallel with G.
REQ-025 Without SOBEL_RGB_EN, only G SHALL be filtered, R and B bits of out_pixel SHALL be 0, and R/B datapath logic SHALL not be instantiated.

Structure
REQ-026 Package sobel_pkg SHALL hold RGB565 field offsets/widths, channel max constants and the FSM state type.
REQ-027 Sub-module sobel_line_buffer (single-port-write, single-port-read RAM, depth IMG_WIDTH, width WORD_SIZE) SHALL be instantiated twice.

Verification
REQ-028 Flat frame, all pixels 0xFFFF, IMG_WIDTH=8, 4 rows -> 32 outputs, all 0x0000, out_sof on first.
REQ-029 Vertical step: cols 0..3 G=0, cols 4..7 G=63, THRESHOLD=0 -> centre cols 3,4 G=63 (saturated from 252), others 0.
REQ-030 Single G=10 pixel at (2,2), THRESHOLD=25 -> neighbours with magnitude 20 give G=0, with 40 give G=40 only where >=25 ... explicitly: diagonal neighbours (|gx|+|gy|=20) ->0, edge neighbours (20+0) ->0 , with THRESHOLD=0 -> 20.
REQ-031 in_valid toggled 1/0 every cycle -> output sequence identical to REQ-029, out_valid pattern delayed 2 cycles.
REQ-032 rst asserted at row 2 col 5, then new frame with in_sof -> no output before new frame; new frame outputs match clean run.
REQ-033 Without SOBEL_RGB_EN, input R/B steps only -> out_pixel=0x0000; with it -> R=31, B=31 at step columns.

Source files
------------

// File: rtl/sobel_pkg.sv
// ============================================================================
// Module   : sobel_pkg
// Brief    : RGB565 field layout, channel limits and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sobel_pkg;

    localparam int c_R_LSB = 11;
    localparam int c_R_W   = 5;
    localparam int c_G_LSB = 5;
    localparam int c_G_W   = 6;
    localparam int c_B_LSB = 0;
    localparam int c_B_W   = 5;

    localparam int c_R_MAX = 31;
    localparam int c_G_MAX = 63;
    localparam int c_B_MAX = 31;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_FILL = 2'd1;
    localparam state_t c_ST_RUN  = 2'd2;

    // Channel index: 0 = B, 1 = G, 2 = R
    function automatic int ch_lsb(input int ch);
        case (ch)
            0:       return c_B_LSB;
            1:       return c_G_LSB;
            default: return c_R_LSB;
        endcase
    endfunction

    function automatic int ch_width(input int ch);
        case (ch)
            0:       return c_B_W;
            1:       return c_G_W;
            default: return c_R_W;
        endcase
    endfunction

    function automatic int ch_max(input int ch);
        case (ch)
            0:       return c_B_MAX;
            1:       return c_G_MAX;
            default: return c_R_MAX;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sobel_line_buffer.sv
// ============================================================================
// Module   : sobel_line_buffer
// Brief    : one-line pixel store, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read returns the pre-write contents when addresses collide
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/sobel_stream.sv
// ============================================================================
// Module   : sobel_stream
// Brief    : streaming 3x3 Sobel filter on RGB565, 2-cycle latency.
//            Define SOBEL_RGB_EN to filter R and B alongside G.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_stream
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int WORD_SIZE = 16,
    parameter int THRESHOLD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [WORD_SIZE-1:0] in_pixel,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic [WORD_SIZE-1:0] out_pixel
);

    localparam int c_AW = $clog2(IMG_WIDTH);
`ifdef SOBEL_RGB_EN
    localparam logic [2:0] c_CH_EN = 3'b111;
`else
    localparam logic [2:0] c_CH_EN = 3'b010;
`endif

    state_t               state_q, state_d;
    logic [c_AW-1:0]      col_q, col_d, w_col_pos;
    logic [1:0]           row_q, row_d, w_row_pos;
    logic                 w_acc;
    logic [WORD_SIZE-1:0] w_lb1_rd, w_lb2_rd;
    logic [WORD_SIZE-1:0] win_q [3][2];
    logic [WORD_SIZE-1:0] w_tap [9];
    logic                 v1_q, sof1_q, zero1_q;
    logic [WORD_SIZE-1:0] w_pix_d;
    logic                 out_valid_q, out_sof_q;
    logic [WORD_SIZE-1:0] out_pixel_q;

    assign w_acc     = in_valid && (in_sof || (state_q != c_ST_IDLE));
    assign w_col_pos = in_sof ? '0 : col_q;
    assign w_row_pos = in_sof ? 2'd0 : row_q;

    // Row count saturates at 2: only "fewer than two rows above" matters
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (w_acc) begin
            if (w_col_pos == c_AW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (w_row_pos == 2'd2) ? 2'd2 : w_row_pos + 2'd1;
            end else begin
                col_d = w_col_pos + c_AW'(1);
                row_d = w_row_pos;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (in_valid && in_sof) state_d = c_ST_FILL;
            c_ST_FILL: begin
                if (in_valid && in_sof)                state_d = c_ST_FILL;
                else if (w_acc && w_row_pos == 2'd2)   state_d = c_ST_RUN;
            end
            c_ST_RUN:  if (in_valid && in_sof) state_d = c_ST_FILL;
            default:   state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(WORD_SIZE)) u_lb1 (
        .clk       (clk),
        .wr_en_i   (w_acc),
        .wr_addr_i (w_col_pos),
        .wr_data_i (in_pixel),
        .rd_addr_i (w_col_pos),
        .rd_data_o (w_lb1_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(WORD_SIZE)) u_lb2 (
        .clk       (clk),
        .wr_en_i   (w_acc),
        .wr_addr_i (w_col_pos),
        .wr_data_i (w_lb1_rd),
        .rd_addr_i (w_col_pos),
        .rd_data_o (w_lb2_rd)
    );

    // Window rows: 0 = r-2 (line buffer 2), 1 = r-1 (line buffer 1), 2 = r (live)
    assign w_tap[0] = win_q[0][0];
    assign w_tap[1] = win_q[0][1];
    assign w_tap[2] = w_lb2_rd;
    assign w_tap[3] = win_q[1][0];
    assign w_tap[4] = win_q[1][1];
    assign w_tap[5] = w_lb1_rd;
    assign w_tap[6] = win_q[2][0];
    assign w_tap[7] = win_q[2][1];
    assign w_tap[8] = in_pixel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= '0;
                win_q[i][1] <= '0;
            end
        end else if (w_acc) begin
            win_q[0][0] <= win_q[0][1];
            win_q[0][1] <= w_lb2_rd;
            win_q[1][0] <= win_q[1][1];
            win_q[1][1] <= w_lb1_rd;
            win_q[2][0] <= win_q[2][1];
            win_q[2][1] <= in_pixel;
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        localparam int c_LSB = ch_lsb(ch);
        localparam int c_CW  = ch_width(ch);
        localparam int c_MAX = ch_max(ch);

        if (c_CH_EN[ch]) begin : g_filt
            logic signed [c_CW+2:0] w_e [9];
            logic signed [c_CW+2:0] w_gx, w_gy, gx_q, gy_q;
            logic        [c_CW+2:0] w_ax, w_ay;
            logic        [c_CW+3:0] w_mag;
            logic        [c_CW-1:0] w_val;
            logic                   w_unused_centre;

            for (genvar k = 0; k < 9; k++) begin : g_tap
                assign w_e[k] = $signed({3'b000, w_tap[k][c_LSB +: c_CW]});
            end
            assign w_unused_centre = ^w_e[4];

            assign w_gx = (w_e[2] - w_e[0]) + ((w_e[5] - w_e[3]) <<< 1) + (w_e[8] - w_e[6]);
            assign w_gy = (w_e[0] - w_e[6]) + ((w_e[1] - w_e[7]) <<< 1) + (w_e[2] - w_e[8]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    gx_q <= '0;
                    gy_q <= '0;
                end else if (w_acc) begin
                    gx_q <= w_gx;
                    gy_q <= w_gy;
                end
            end

            assign w_ax  = gx_q[c_CW+2] ? -gx_q : gx_q;
            assign w_ay  = gy_q[c_CW+2] ? -gy_q : gy_q;
            assign w_mag = {1'b0, w_ax} + {1'b0, w_ay};

            always_comb begin
                w_val = w_mag[c_CW-1:0];
                if (int'(w_mag) < THRESHOLD) begin
                    w_val = '0;
                end else if (int'(w_mag) > c_MAX) begin
                    w_val = c_CW'(c_MAX);
                end
            end

            assign w_pix_d[c_LSB +: c_CW] = w_val;
        end else begin : g_zero
            logic w_unused_ch;
            assign w_unused_ch = ^{w_tap[0][c_LSB +: c_CW], w_tap[1][c_LSB +: c_CW],
                                   w_tap[2][c_LSB +: c_CW], w_tap[3][c_LSB +: c_CW],
                                   w_tap[4][c_LSB +: c_CW], w_tap[5][c_LSB +: c_CW],
                                   w_tap[6][c_LSB +: c_CW], w_tap[7][c_LSB +: c_CW],
                                   w_tap[8][c_LSB +: c_CW]};
            assign w_pix_d[c_LSB +: c_CW] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            sof1_q  <= 1'b0;
            zero1_q <= 1'b0;
        end else begin
            v1_q <= w_acc;
            if (w_acc) begin
                sof1_q  <= in_sof;
                zero1_q <= (w_row_pos < 2'd2) || (w_col_pos < c_AW'(2));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_pixel_q <= '0;
        end else begin
            out_valid_q <= v1_q;
            out_sof_q   <= v1_q && sof1_q;
            if (v1_q) begin
                out_pixel_q <= zero1_q ? '0 : w_pix_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_pixel = out_pixel_q;

endmodule

`default_nettype wire

// File: tb/tb_sobel_stream.sv
// ============================================================================
// Module   : tb_sobel_stream
// Brief    : scoreboard bench for sobel_stream against a frame-array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sobel_stream;

    localparam int W    = 8;
    localparam int THR1 = 25;
`ifdef SOBEL_RGB_EN
    localparam bit RGB = 1'b1;
`else
    localparam bit RGB = 1'b0;
`endif

    typedef struct {
        int          due;
        logic        sof;
        logic [15:0] pix;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [15:0] in_pixel = 16'h0;
    logic        ov0, os0, ov1, os1;
    logic [15:0] op0, op1;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic [15:0] img [0:63][0:W-1];
    int          m_r = 0, m_c = 0;
    bit          m_active = 1'b0;

    sobel_stream #(.IMG_WIDTH(W), .WORD_SIZE(16), .THRESHOLD(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .out_valid(ov0), .out_sof(os0), .out_pixel(op0)
    );

    sobel_stream #(.IMG_WIDTH(W), .WORD_SIZE(16), .THRESHOLD(THR1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .out_valid(ov1), .out_sof(os1), .out_pixel(op1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int chan(input logic [15:0] p, input int ch);
        case (ch)
            0:       return int'(p[4:0]);
            1:       return int'(p[10:5]);
            default: return int'(p[15:11]);
        endcase
    endfunction

    // Sobel of the 3x3 neighbourhood centred at (r-1, c-1) of the stored frame
    function automatic logic [15:0] ref_pix(input int r, input int c, input int thr);
        logic [15:0] res;
        int p[9];
        int gx, gy, mag, mx, v, sh;
        res = 16'h0;
        if (r < 2 || c < 2) return res;
        for (int ch = 0; ch < 3; ch++) begin
            if (ch != 1 && !RGB) continue;
            for (int k = 0; k < 9; k++) p[k] = chan(img[r-2+k/3][c-2+k%3], ch);
            gx  = (p[2] - p[0]) + 2 * (p[5] - p[3]) + (p[8] - p[6]);
            gy  = (p[0] - p[6]) + 2 * (p[1] - p[7]) + (p[2] - p[8]);
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            mx  = (ch == 1) ? 63 : 31;
            v   = (mag < thr) ? 0 : ((mag > mx) ? mx : mag);
            sh  = (ch == 0) ? 0 : ((ch == 1) ? 5 : 11);
            res = res | 16'(v << sh);
        end
        return res;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [15:0] pix);
        exp_t e;
        @(posedge clk); #1;
        in_valid = v;
        in_sof   = s;
        in_pixel = pix;
        if (v) begin
            if (s) begin
                m_active = 1'b1;
                m_r = 0;
                m_c = 0;
            end
            if (m_active) begin
                img[m_r][m_c] = pix;
                e.due = cyc + 2;
                e.sof = s;
                e.pix = ref_pix(m_r, m_c, 0);
                q0.push_back(e);
                e.pix = ref_pix(m_r, m_c, THR1);
                q1.push_back(e);
                if (m_c == W - 1) begin
                    m_c = 0;
                    m_r++;
                end else begin
                    m_c++;
                end
            end
        end
    endtask

    // kind: 0 flat, 1 G step, 2 G impulse, 3 R/B step, 4 random, 5 low-contrast random
    // gmode: 0 no gaps, 1 alternate valid, 2 random gaps
    task automatic send_frame(input int kind, input int rows, input int gmode,
                              input int stop_r, input int stop_c);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < W; c++) begin
                logic [15:0] pix;
                int gap;
                case (kind)
                    0:       pix = 16'hFFFF;
                    1:       pix = (c >= 4) ? 16'h07E0 : 16'h0000;
                    2:       pix = (r == 2 && c == 2) ? 16'(10 << 5) : 16'h0000;
                    3:       pix = (c >= 4) ? 16'hF81F : 16'h0000;
                    4:       pix = 16'($urandom);
                    default: pix = {5'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                                    5'($urandom_range(0, 7))};
                endcase
                gap = 0;
                if (gmode == 1) gap = 1;
                else if (gmode == 2 && $urandom_range(0, 3) == 0) gap = int'($urandom_range(1, 2));
                repeat (gap) drive(1'b0, 1'($urandom), 16'($urandom));
                drive(1'b1, (r == 0 && c == 0), pix);
                if (r == stop_r && c == stop_c) return;
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_out(input int id, input logic s, input logic [15:0] p);
        exp_t e;
        n_cmp++;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            n_fail++;
            $display("FAIL unexpected_out dut%0d: got pix=%h sof=%b at cyc %0d, required no output",
                     id, p, s, cyc);
            return;
        end
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        if (e.pix !== p || e.sof !== s || e.due != cyc) begin
            n_fail++;
            $display("FAIL out dut%0d: got pix=%h sof=%b cyc=%0d, required pix=%h sof=%b cyc=%0d",
                     id, p, s, cyc, e.pix, e.sof, e.due);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst      = 1'b1;
        q0.delete();
        q1.delete();
        m_active = 1'b0;
        @(negedge clk);
        chk("midrst_valid0", {15'b0, ov0}, 16'h0);
        chk("midrst_valid1", {15'b0, ov1}, 16'h0);
        chk("midrst_pixel0", op0, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ov0) check_out(0, os0, op0);
        if (ov1) check_out(1, os1, op1);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid0", {15'b0, ov0}, 16'h0);
        chk("reset_sof0",   {15'b0, os0}, 16'h0);
        chk("reset_pixel0", op0, 16'h0);
        chk("reset_valid1", {15'b0, ov1}, 16'h0);
        chk("reset_pixel1", op1, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        repeat (5) drive(1'b1, 1'b0, 16'($urandom));
        send_frame(0, 4, 0, -1, -1);
        send_frame(1, 4, 0, -1, -1);
        send_frame(2, 5, 0, -1, -1);
        send_frame(1, 4, 1, -1, -1);
        send_frame(1, 4, 2, 2, 5);
        do_reset();
        repeat (4) drive(1'b1, 1'b0, 16'($urandom));
        send_frame(1, 4, 0, -1, -1);
        send_frame(3, 4, 0, -1, -1);
        for (int f = 0; f < 10; f++) begin
            int rows;
            rows = int'($urandom_range(3, 5));
            if ($urandom_range(0, 2) == 0)
                send_frame(4 + (f % 2), rows, 2, int'($urandom_range(1, rows - 1)),
                           int'($urandom_range(0, W - 1)));
            else
                send_frame(4 + (f % 2), rows, 2, -1, -1);
        end

        for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++)
            drive(1'b0, 1'b0, 16'h0);
        repeat (3) @(negedge clk);
        chk("drain_q0_left", 16'(q0.size()), 16'h0);
        chk("drain_q1_left", 16'(q1.size()), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
